// File: rtl/video_timing_pkg.sv
// Shared timing constants, sync polarity values and the window-decode helpers
// used by video_timing_gen.
package video_timing_pkg;

   localparam int unsigned FF_CLK_DIV    = 2;
   localparam int unsigned FF_H_BITS     = 9;
   localparam int unsigned FF_V_BITS     = 9;
   localparam int unsigned FF_H_FIRST    = 128;
   localparam int unsigned FF_H_LAST     = 511;
   localparam int unsigned FF_V_FIRST    = 0;
   localparam int unsigned FF_V_LAST     = 259;
   localparam int unsigned FF_HBLANK_ON  = 128;
   localparam int unsigned FF_HBLANK_OFF = 256;
   localparam int unsigned FF_HSYNC_ON   = 160;
   localparam int unsigned FF_HSYNC_OFF  = 192;
   localparam int unsigned FF_VBLANK_ON  = 240;
   localparam int unsigned FF_VBLANK_OFF = 0;
   localparam int unsigned FF_VSYNC_ON   = 244;
   localparam int unsigned FF_VSYNC_OFF  = 248;

   localparam int unsigned POL_ACTIVE_LOW  = 0;
   localparam int unsigned POL_ACTIVE_HIGH = 1;

   // ON<OFF is a plain window, ON>OFF wraps past the end of the axis, ON==OFF is empty
   function automatic logic in_window(input int unsigned x, input int unsigned on,
                                      input int unsigned off);
      if (on < off) return (x >= on) && (x < off);
      else if (on > off) return (x >= on) || (x < off);
      else return 1'b0;
   endfunction

   function automatic logic bound_ok(input int unsigned b, input int unsigned first,
                                     input int unsigned last);
      return (b >= first) && (b <= last + 1);
   endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// Enabled up-counter running FIRST..LAST that reloads FIRST after LAST;
// exposes its next value so callers can register decodes with zero skew.
module wrap_counter #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned FIRST = 0,
   parameter int unsigned LAST  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   output logic [WIDTH-1:0] q_o,
   output logic             wrap_c_o,
   output logic [WIDTH-1:0] next_c_o
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d      = q_q;
      wrap_c_o = !reset && en_i && (q_q == WIDTH'(LAST));
      if (wrap_c_o)  q_d = WIDTH'(FIRST);
      else if (en_i) q_d = q_q + WIDTH'(1);
      next_c_o = reset ? WIDTH'(FIRST) : q_d;
   end

   always_ff @(posedge clk) begin
      if (reset) q_q <= WIDTH'(FIRST);
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel clock-enable, H/V counters, sync/blank and
// line/frame strobes. Optional line interrupt under VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV    = FF_CLK_DIV,
   parameter int unsigned H_BITS     = FF_H_BITS,
   parameter int unsigned V_BITS     = FF_V_BITS,
   parameter int unsigned H_FIRST    = FF_H_FIRST,
   parameter int unsigned H_LAST     = FF_H_LAST,
   parameter int unsigned V_FIRST    = FF_V_FIRST,
   parameter int unsigned V_LAST     = FF_V_LAST,
   parameter int unsigned HBLANK_ON  = FF_HBLANK_ON,
   parameter int unsigned HBLANK_OFF = FF_HBLANK_OFF,
   parameter int unsigned HSYNC_ON   = FF_HSYNC_ON,
   parameter int unsigned HSYNC_OFF  = FF_HSYNC_OFF,
   parameter int unsigned VBLANK_ON  = FF_VBLANK_ON,
   parameter int unsigned VBLANK_OFF = FF_VBLANK_OFF,
   parameter int unsigned VSYNC_ON   = FF_VSYNC_ON,
   parameter int unsigned VSYNC_OFF  = FF_VSYNC_OFF,
   parameter int unsigned HSYNC_POL  = POL_ACTIVE_HIGH,
   parameter int unsigned VSYNC_POL  = POL_ACTIVE_HIGH
) (
   input  logic              clk,
   input  logic              reset,
   output logic              pix_ce,
   output logic [H_BITS-1:0] h_count,
   output logic [V_BITS-1:0] v_count,
   output logic              hsync,
   output logic              hblank,
   output logic              vsync,
   output logic              vblank,
   output logic              line_start,
   output logic              frame_start
`ifdef VIDEO_TIMING_LINE_IRQ_EN
   ,
   input  logic [V_BITS-1:0] irq_line,
   input  logic              irq_ack,
   output logic              irq
`endif
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam bit CFG_OK =
      (CLK_DIV >= 1) && (CLK_DIV <= 16) &&
      (H_LAST > H_FIRST) && (V_LAST > V_FIRST) &&
      ((H_LAST >> H_BITS) == 0) && ((V_LAST >> V_BITS) == 0) &&
      bound_ok(HBLANK_ON, H_FIRST, H_LAST) && bound_ok(HBLANK_OFF, H_FIRST, H_LAST) &&
      bound_ok(HSYNC_ON, H_FIRST, H_LAST)  && bound_ok(HSYNC_OFF, H_FIRST, H_LAST) &&
      bound_ok(VBLANK_ON, V_FIRST, V_LAST) && bound_ok(VBLANK_OFF, V_FIRST, V_LAST) &&
      bound_ok(VSYNC_ON, V_FIRST, V_LAST)  && bound_ok(VSYNC_OFF, V_FIRST, V_LAST);

   if (!CFG_OK) begin : g_cfg_err
      $error("video_timing_gen: illegal timing parameter set");
   end

   logic [DIV_W-1:0]  div_q, div_d;
   logic              pix_ce_q, pix_ce_d;
   logic              line_start_q, frame_start_q;
   logic              hsync_q, hsync_d, hblank_q, hblank_d;
   logic              vsync_q, vsync_d, vblank_q, vblank_d;
   logic              h_wrap, v_wrap;
   logic [H_BITS-1:0] h_next;
   logic [V_BITS-1:0] v_next;

   // Divider: pix_ce is the registered decode of the last divider phase
   always_comb begin
      div_d    = div_q + DIV_W'(1);
      pix_ce_d = (div_q == DIV_W'(CLK_DIV - 1));
      if (pix_ce_d) div_d = '0;
   end

   wrap_counter #(.WIDTH(H_BITS), .FIRST(H_FIRST), .LAST(H_LAST)) u_h_cnt (
      .clk      (clk),
      .reset    (reset),
      .en_i     (pix_ce_d),
      .q_o      (h_count),
      .wrap_c_o (h_wrap),
      .next_c_o (h_next)
   );

   wrap_counter #(.WIDTH(V_BITS), .FIRST(V_FIRST), .LAST(V_LAST)) u_v_cnt (
      .clk      (clk),
      .reset    (reset),
      .en_i     (h_wrap),
      .q_o      (v_count),
      .wrap_c_o (v_wrap),
      .next_c_o (v_next)
   );

   // Decode from next counter values so outputs register alongside the counters
   always_comb begin
      hblank_d = in_window(32'(h_next), HBLANK_ON, HBLANK_OFF);
      vblank_d = in_window(32'(v_next), VBLANK_ON, VBLANK_OFF);
      hsync_d  = in_window(32'(h_next), HSYNC_ON, HSYNC_OFF);
      vsync_d  = in_window(32'(v_next), VSYNC_ON, VSYNC_OFF);
      if (HSYNC_POL == POL_ACTIVE_LOW) hsync_d = !hsync_d;
      if (VSYNC_POL == POL_ACTIVE_LOW) vsync_d = !vsync_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         pix_ce_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         pix_ce_q      <= pix_ce_d;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
      end
      hsync_q  <= hsync_d;
      hblank_q <= hblank_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
   end

   assign pix_ce      = pix_ce_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign hsync       = hsync_q;
   assign hblank      = hblank_q;
   assign vsync       = vsync_q;
   assign vblank      = vblank_q;

`ifdef VIDEO_TIMING_LINE_IRQ_EN
   logic irq_q, irq_d;

   // A set on the wrap into irq_line beats a simultaneous acknowledge
   always_comb begin
      irq_d = irq_q;
      if (irq_ack) irq_d = 1'b0;
      if (h_wrap && (v_next == irq_line)) irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif

endmodule
